uartwb_host: RTL and testbench
==============================

Name: uartwb_host

Overview:
- Host-side initiator for the UART-Wishbone byte protocol. Accepts one parallel read/write request and serializes it into command, address and data bytes toward a UART Tx buffer.
- Then parses the response bytes from a UART receiver: command echo, plus read data for reads.
- Used in loopback benches and board-to-board links to drive a remote UART-WB bridge from local logic.

Parameters:
- ADDR_WID, 32, address width in bits; multiple of 8, range 8..248.
- DATA_WID, 32, data width in bits; multiple of 8, range 8..248.
- TIMEOUT, 16'hFFFF, response timeout in clk_i cycles (16-bit); 0 disables the timeout.

Ports:
- clk_i  in  1  single clock
- nrst_i  in  1  reset, synchronous, active-low
- req_en_i  in  1  single-cycle request strobe; ignored while busy_o=1
- req_wr_i  in  1  1=write, 0=read; sampled with req_en_i
- req_addr_i  in  ADDR_WID  address; sampled with req_en_i
- req_data_i  in  DATA_WID  write data; sampled with req_en_i (also sent on reads)
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  single-cycle completion pulse
- err_o  out  2  [0]=echo mismatch, [1]=timeout; valid from done_o, held until next accepted request
- rdata_o  out  DATA_WID  read data; valid from done_o, held until next accepted request
- uarttx_en_o  out  1  single-cycle byte push into Tx buffer
- uarttx_data_o  out  8  byte pushed; 0 when uarttx_en_o=0
- uarttx_ready_i  in  1  Tx buffer can accept a byte this cycle
- uartrx_valid_i  in  1  receiver byte valid; rising-edge qualified
- uartrx_data_i  in  8  received byte

Behaviour:
- Reset values: busy_o=0, done_o=0, err_o=0, rdata_o=0, uarttx_en_o=0, uarttx_data_o=0. State=IDLE, byte counter=0, timeout counter=0.
- Rx valid edge-detect register resets to 1. rx_en = uartrx_valid_i & !valid_q. A valid held high counts once; a valid already high at reset release is not counted.
- Command byte: 8'h01 for write, 8'h00 for read.
- Address and data are sent MSB byte first. DATA_BYTES data bytes are always sent, including on reads.
- States: IDLE, TX_CMD, TX_ADDR, TX_DATA, RX_ECHO, RX_DATA, DONE.
- IDLE:
  - req_en_i=1 latches wr, addr, data and cmd, clears err_o and rdata_o, and goes to TX_CMD next cycle.
  - rx_en in IDLE is ignored.
- TX states:
  - uarttx_en_o = uarttx_ready_i (combinational); uarttx_data_o = current byte.
  - A byte is consumed only in a cycle with uarttx_ready_i=1.
  - Order: TX_CMD 1 byte -> TX_ADDR ADDR_BYTES -> TX_DATA DATA_BYTES -> RX_ECHO.
  - With ready held high, the request takes 1+ADDR_BYTES+DATA_BYTES consecutive cycles starting the cycle after req_en_i.
  - rx_en during TX states is ignored.
- RX_ECHO, on rx_en:
  - Byte == cmd and wr=1 -> DONE.
  - Byte == cmd and wr=0 -> RX_DATA.
  - Byte != cmd -> set err_o[0], go to DONE. Remaining stray bytes are then ignored in IDLE.
- RX_DATA:
  - On each rx_en, rdata shifts left 8 and takes the byte in the LSBs.
  - After DATA_BYTES bytes -> DONE.
- Timeout:
  - The counter clears on entry to RX_ECHO and on every rx_en in the RX states, and increments otherwise.
  - When the counter reaches TIMEOUT (TIMEOUT != 0): set err_o[1], go to DONE, and leave rdata_o with any partially shifted value.
  - rx_en in the same cycle as expiry takes priority; the byte is processed and the counter clears.
- DONE: done_o=1 for exactly one cycle, then IDLE. Completion latency is 1 cycle after the final rx_en.
- A new req_en_i is accepted on the cycle after DONE, the first cycle in IDLE.
- Byte counter is 5 bits. It clears on every state change and wraps to 0 at the last byte of each field.
- nrst_i low mid-transfer aborts immediately to IDLE with reset values; no partial byte stream resumes.

Test Plan:
- Write, ADDR 0x00001000, DATA 0xDEADBEEF, ready=1 -> Tx bytes 01 00 00 10 00 DE AD BE EF on 9 consecutive cycles. Then inject echo 01 -> done_o one cycle later, err_o=00.
- Read, ADDR 0x00000020 -> Tx 00 00 00 00 20 00 00 00 00. Then inject 00 12 34 56 78 -> done_o, rdata_o=0x12345678, err_o=00.
- Backpressure: toggle uarttx_ready_i 1/0 every cycle during the write above -> same 9 bytes in order, each uarttx_en_o only when ready=1. Also pulse req_en_i while busy -> request ignored.
- Echo mismatch: read request, respond 05 -> done_o, err_o=01, rdata_o=0. Following bytes 12 34 are ignored and busy_o stays 0.
- Timeout: TIMEOUT=100, read request, respond 00 12 then silence -> done_o 100 cycles after the last byte, err_o=10, rdata_o=0x00000012.
- Rx valid held high 10 cycles per byte counts once per byte. Assert nrst_i low mid-TX_ADDR -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/uartwb_host.sv
// Host-side initiator for the UART-Wishbone byte protocol: serialises one read/write
// request as cmd/addr/data bytes toward a Tx buffer, then parses the echo and read data.
module uartwb_host #(
    parameter int          ADDR_WID = 32,
    parameter int          DATA_WID = 32,
    parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
    input  logic                clk_i,
    input  logic                nrst_i,
    input  logic                req_en_i,
    input  logic                req_wr_i,
    input  logic [ADDR_WID-1:0] req_addr_i,
    input  logic [DATA_WID-1:0] req_data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [1:0]          err_o,
    output logic [DATA_WID-1:0] rdata_o,
    output logic                uarttx_en_o,
    output logic [7:0]          uarttx_data_o,
    input  logic                uarttx_ready_i,
    input  logic                uartrx_valid_i,
    input  logic [7:0]          uartrx_data_i
);

    localparam int         ADDR_BYTES = ADDR_WID / 8;
    localparam int         DATA_BYTES = DATA_WID / 8;
    localparam logic [4:0] ADDR_LAST  = 5'(ADDR_BYTES - 1);
    localparam logic [4:0] DATA_LAST  = 5'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX_CMD  = 3'd1,
        S_TX_ADDR = 3'd2,
        S_TX_DATA = 3'd3,
        S_RX_ECHO = 3'd4,
        S_RX_DATA = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_wr;
    logic [ADDR_WID-1:0] r_addr_sh;
    logic [DATA_WID-1:0] r_data_sh;
    logic [DATA_WID-1:0] r_rdata;
    logic [1:0]          r_err;
    logic [4:0]          r_cnt;
    logic [15:0]         r_tmo;
    logic                r_valid_q;

    logic        w_rx_en;
    logic        w_tx_state;
    logic        w_rx_state;
    logic        w_tx_take;
    logic        w_tmo_hit;
    logic [7:0]  w_cmd;
    logic [7:0]  w_tx_byte;
    logic [15:0] w_tmo_inc;

    assign w_cmd      = {7'd0, r_wr};
    assign w_rx_en    = uartrx_valid_i & ~r_valid_q;
    assign w_tx_state = (r_state == S_TX_CMD) || (r_state == S_TX_ADDR) || (r_state == S_TX_DATA);
    assign w_rx_state = (r_state == S_RX_ECHO) || (r_state == S_RX_DATA);
    assign w_tx_take  = w_tx_state & uarttx_ready_i;
    assign w_tmo_inc  = r_tmo + 16'd1;
    // Expiry fires when the silent-cycle count would reach TIMEOUT; a byte arriving that cycle wins.
    assign w_tmo_hit  = (TIMEOUT != 16'd0) && w_rx_state && !w_rx_en && (w_tmo_inc == TIMEOUT);

    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = (r_state == S_DONE);
    assign err_o         = r_err;
    assign rdata_o       = r_rdata;
    assign uarttx_en_o   = w_tx_take;
    assign uarttx_data_o = w_tx_take ? w_tx_byte : 8'h00;

    // Byte currently presented to the Tx buffer.
    always_comb begin
        w_tx_byte = 8'h00;
        case (r_state)
            S_TX_CMD:  w_tx_byte = w_cmd;
            S_TX_ADDR: w_tx_byte = r_addr_sh[ADDR_WID-1 -: 8];
            S_TX_DATA: w_tx_byte = r_data_sh[DATA_WID-1 -: 8];
            default:   w_tx_byte = 8'h00;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_en_i) w_state_nxt = S_TX_CMD;
                else          w_state_nxt = S_IDLE;
            end
            S_TX_CMD: begin
                if (uarttx_ready_i) w_state_nxt = S_TX_ADDR;
                else                w_state_nxt = S_TX_CMD;
            end
            S_TX_ADDR: begin
                if (uarttx_ready_i && (r_cnt == ADDR_LAST)) w_state_nxt = S_TX_DATA;
                else                                        w_state_nxt = S_TX_ADDR;
            end
            S_TX_DATA: begin
                if (uarttx_ready_i && (r_cnt == DATA_LAST)) w_state_nxt = S_RX_ECHO;
                else                                        w_state_nxt = S_TX_DATA;
            end
            S_RX_ECHO: begin
                if (w_rx_en) begin
                    if ((uartrx_data_i == w_cmd) && !r_wr) w_state_nxt = S_RX_DATA;
                    else                                   w_state_nxt = S_DONE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RX_ECHO;
                end
            end
            S_RX_DATA: begin
                if (w_rx_en) begin
                    if (r_cnt == DATA_LAST) w_state_nxt = S_DONE;
                    else                    w_state_nxt = S_RX_DATA;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RX_DATA;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Request latch, Tx shifters, Rx assembly, byte/timeout counters and error flags.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            r_wr      <= 1'b0;
            r_addr_sh <= '0;
            r_data_sh <= '0;
            r_rdata   <= '0;
            r_err     <= 2'b00;
            r_cnt     <= 5'd0;
            r_tmo     <= 16'd0;
            r_valid_q <= 1'b1;
        end else begin
            r_valid_q <= uartrx_valid_i;

            if (w_state_nxt != r_state)                 r_cnt <= 5'd0;
            else if (w_tx_take)                         r_cnt <= r_cnt + 5'd1;
            else if ((r_state == S_RX_DATA) && w_rx_en) r_cnt <= r_cnt + 5'd1;

            // Zero outside the Rx phase, so entry into RX_ECHO always starts from a cleared count.
            if (!w_rx_state || w_rx_en) r_tmo <= 16'd0;
            else                        r_tmo <= w_tmo_inc;

            case (r_state)
                S_IDLE: begin
                    if (req_en_i) begin
                        r_wr      <= req_wr_i;
                        r_addr_sh <= req_addr_i;
                        r_data_sh <= req_data_i;
                        r_rdata   <= '0;
                        r_err     <= 2'b00;
                    end
                end
                S_TX_ADDR: begin
                    if (uarttx_ready_i) r_addr_sh <= r_addr_sh << 8;
                end
                S_TX_DATA: begin
                    if (uarttx_ready_i) r_data_sh <= r_data_sh << 8;
                end
                S_RX_ECHO: begin
                    if (w_rx_en && (uartrx_data_i != w_cmd)) r_err[0] <= 1'b1;
                    if (w_tmo_hit)                           r_err[1] <= 1'b1;
                end
                S_RX_DATA: begin
                    if (w_rx_en)   r_rdata  <= (r_rdata << 8) | DATA_WID'(uartrx_data_i);
                    if (w_tmo_hit) r_err[1] <= 1'b1;
                end
                default: begin
                    r_wr <= r_wr;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uartwb_host.sv
// Directed bench for uartwb_host: write/read framing, backpressure, echo mismatch,
// response timeout, held Rx valid and mid-transfer reset.
module tb_uartwb_host;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_en;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  err_o;
    logic [31:0] rdata_o;
    logic        uarttx_en_o;
    logic [7:0]  uarttx_data_o;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [7:0] wr_bytes [0:8];
    logic [7:0] rd_bytes [0:8];

    always #5 clk = ~clk;

    uartwb_host #(
        .ADDR_WID (32),
        .DATA_WID (32),
        .TIMEOUT  (16'd100)
    ) dut (
        .clk_i          (clk),
        .nrst_i         (nrst),
        .req_en_i       (req_en),
        .req_wr_i       (req_wr),
        .req_addr_i     (req_addr),
        .req_data_i     (req_data),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .rdata_o        (rdata_o),
        .uarttx_en_o    (uarttx_en_o),
        .uarttx_data_o  (uarttx_data_o),
        .uarttx_ready_i (tx_ready),
        .uartrx_valid_i (rx_valid),
        .uartrx_data_i  (rx_data)
    );

    always @(posedge clk) if (done_o) done_cnt++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        req_en   = 1'b1;
        req_wr   = wr;
        req_addr = addr;
        req_data = data;
        cyc();
        req_en   = 1'b0;
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] b);
        @(negedge clk);
        chk({tag, "_en"}, {31'd0, uarttx_en_o}, 32'd1);
        chk({tag, "_byte"}, {24'd0, uarttx_data_o}, {24'd0, b});
        cyc();
    endtask

    // Returns 'hold' cycles after the cycle in which the byte's rising valid edge is seen.
    task automatic rx_byte(input logic [7:0] b, input int hold);
        rx_valid = 1'b0;
        cyc();
        rx_valid = 1'b1;
        rx_data  = b;
        repeat (hold) cyc();
        rx_valid = 1'b0;
    endtask

    initial begin
        int   idx;
        int   dc0;
        logic early;

        wr_bytes = '{8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        rd_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        nrst     = 1'b0;
        req_en   = 1'b0;
        req_wr   = 1'b0;
        req_addr = 32'h0;
        req_data = 32'h0;
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) cyc();

        @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {30'd0, err_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_txen", {31'd0, uarttx_en_o}, 32'd0);
        chk("rst_txdata", {24'd0, uarttx_data_o}, 32'd0);
        cyc();
        nrst = 1'b1;
        cyc();

        // Write with ready held high: nine back-to-back bytes, then echo.
        start_req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        for (int i = 0; i < 9; i++) expect_tx("wr_tx", wr_bytes[i]);
        @(negedge clk);
        chk("wr_echo_wait_en", {31'd0, uarttx_en_o}, 32'd0);
        chk("wr_echo_wait_busy", {31'd0, busy_o}, 32'd1);
        rx_byte(8'h01, 1);
        @(negedge clk);
        chk("wr_done", {31'd0, done_o}, 32'd1);
        chk("wr_err", {30'd0, err_o}, 32'd0);
        cyc();
        @(negedge clk);
        chk("wr_done_single", {31'd0, done_o}, 32'd0);
        chk("wr_idle_busy", {31'd0, busy_o}, 32'd0);

        // Read: echo 00 followed by four data bytes, MSB first.
        start_req(1'b0, 32'h0000_0020, 32'h0);
        for (int i = 0; i < 9; i++) expect_tx("rd_tx", rd_bytes[i]);
        rx_byte(8'h00, 1);
        rx_byte(8'h12, 1);
        rx_byte(8'h34, 1);
        rx_byte(8'h56, 1);
        rx_byte(8'h78, 1);
        @(negedge clk);
        chk("rd_done", {31'd0, done_o}, 32'd1);
        chk("rd_rdata", rdata_o, 32'h1234_5678);
        chk("rd_err", {30'd0, err_o}, 32'd0);
        cyc();

        // Backpressure with ready toggling; a request pulsed while busy must be ignored.
        start_req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        idx = 0;
        for (int i = 0; i < 40 && idx < 9; i++) begin
            tx_ready = i[0];
            if (i == 3) begin
                req_en   = 1'b1;
                req_wr   = 1'b0;
                req_addr = 32'hFFFF_FFFF;
                req_data = 32'h5555_5555;
            end else begin
                req_en = 1'b0;
            end
            @(negedge clk);
            chk("bp_en_follows_ready", {31'd0, uarttx_en_o}, {31'd0, tx_ready});
            if (uarttx_en_o) begin
                chk("bp_byte", {24'd0, uarttx_data_o}, {24'd0, wr_bytes[idx]});
                idx++;
            end
            cyc();
        end
        req_en   = 1'b0;
        tx_ready = 1'b1;
        chk("bp_byte_count", idx, 32'd9);
        rx_byte(8'h01, 1);
        @(negedge clk);
        chk("bp_done", {31'd0, done_o}, 32'd1);
        chk("bp_err", {30'd0, err_o}, 32'd0);
        cyc();
        @(negedge clk);
        chk("bp_no_queued_req_en", {31'd0, uarttx_en_o}, 32'd0);
        chk("bp_no_queued_req_busy", {31'd0, busy_o}, 32'd0);

        // Echo mismatch: wrong echo ends the read, trailing bytes are ignored in IDLE.
        start_req(1'b0, 32'h0000_0020, 32'h0);
        repeat (9) cyc();
        rx_byte(8'h05, 1);
        @(negedge clk);
        chk("mm_done", {31'd0, done_o}, 32'd1);
        chk("mm_err", {30'd0, err_o}, 32'd1);
        chk("mm_rdata", rdata_o, 32'd0);
        cyc();
        dc0 = done_cnt;
        rx_byte(8'h12, 1);
        @(negedge clk);
        chk("mm_stray1_busy", {31'd0, busy_o}, 32'd0);
        rx_byte(8'h34, 1);
        @(negedge clk);
        chk("mm_stray2_busy", {31'd0, busy_o}, 32'd0);
        chk("mm_stray_no_done", done_cnt, dc0);
        chk("mm_err_held", {30'd0, err_o}, 32'd1);
        cyc();

        // Rx valid held high for 10 cycles per byte counts once per byte.
        dc0 = done_cnt;
        start_req(1'b0, 32'h0000_0040, 32'h0);
        repeat (9) cyc();
        rx_byte(8'h00, 10);
        rx_byte(8'hAB, 10);
        rx_byte(8'hCD, 10);
        rx_byte(8'hEF, 10);
        rx_byte(8'h01, 10);
        cyc();
        @(negedge clk);
        chk("hold_rdata", rdata_o, 32'hABCD_EF01);
        chk("hold_err", {30'd0, err_o}, 32'd0);
        chk("hold_busy", {31'd0, busy_o}, 32'd0);
        chk("hold_done_once", done_cnt - dc0, 32'd1);
        cyc();

        // Timeout: two bytes then silence; done after 100 silent cycles, partial data kept.
        start_req(1'b0, 32'h0000_0020, 32'h0);
        repeat (9) cyc();
        rx_byte(8'h00, 1);
        rx_byte(8'h12, 1);
        early = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (done_o) early = 1'b1;
            cyc();
        end
        chk("tmo_not_early", {31'd0, early}, 32'd0);
        @(negedge clk);
        chk("tmo_done", {31'd0, done_o}, 32'd1);
        chk("tmo_err", {30'd0, err_o}, 32'd2);
        chk("tmo_rdata", rdata_o, 32'h0000_0012);
        cyc();

        // Reset while idle clears the held result registers.
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        @(negedge clk);
        chk("idle_rst_err", {30'd0, err_o}, 32'd0);
        chk("idle_rst_rdata", rdata_o, 32'd0);
        cyc();

        // Reset in the middle of the address field aborts the transfer for good.
        start_req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        expect_tx("ab_tx", 8'h01);
        expect_tx("ab_tx", 8'h00);
        expect_tx("ab_tx", 8'h00);
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        @(negedge clk);
        chk("ab_busy", {31'd0, busy_o}, 32'd0);
        chk("ab_done", {31'd0, done_o}, 32'd0);
        chk("ab_txen", {31'd0, uarttx_en_o}, 32'd0);
        chk("ab_txdata", {24'd0, uarttx_data_o}, 32'd0);
        chk("ab_err", {30'd0, err_o}, 32'd0);
        chk("ab_rdata", rdata_o, 32'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ab_no_resume", {31'd0, uarttx_en_o}, 32'd0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
